shift_left_sequential: RTL and testbench
========================================

Name: shift_left_sequential

Overview:
- Multi-cycle logical left shifter for the 8-bit ALU. It is the opposite-direction counterpart to the combinational arithmetic right shifter.
- Shifts operand a left by b positions, one bit per clock, zero-filling from the LSB. Reports the last bit shifted out as carry.
- Sits beside the combinational ALU ops. It uses a start/done handshake so the ALU sequencer can issue shifts without a wide barrel-mux.

Parameters:
- WIDTH, 8, operand, result and shift-amount width.
- CNT_W, $clog2(WIDTH+1), width of the internal shift counter. Derived; do not override.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; accepted only when busy=0
- a  input  WIDTH  operand to shift
- b  input  WIDTH  unsigned shift amount
- r  output  WIDTH  shifted result; valid when done=1, held until next accepted start
- carry  output  1  last bit shifted out of the MSB
- busy  output  1  high while shifting; start is ignored
- done  output  1  one-cycle pulse: r and carry are final

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-shift):
  - state goes to IDLE.
  - r=0, carry=0, busy=0, done=0.
  - Counter and accumulator are cleared.
  - rst has priority over start.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
- Accept rule: start=1 while state is IDLE or DONE.
  - On accept, the accumulator is loaded with a and carry is cleared to 0.
  - n = min(b, WIDTH) is loaded into the counter. Any b >= WIDTH saturates to WIDTH.
  - If n=0, the next state is DONE. Otherwise the next state is SHIFT.
- SHIFT, every cycle:
  - acc <= {acc[WIDTH-2:0], 1'b0}
  - carry <= acc[WIDTH-1]
  - count <= count-1
  - When count==1, the next state is DONE.
- DONE:
  - Lasts exactly one cycle; done=1.
  - If start=1 in this cycle, a new op is accepted (back-to-back) and done is not extended. Otherwise the next state is IDLE.
- Latency: done is asserted n+1 cycles after the accept edge.
  - b=0: 1 cycle.
  - b>=8: 9 cycles (WIDTH=8).
- start while busy=1 is ignored. a and b are sampled only at accept, so they may change freely during SHIFT.
- r is driven from the accumulator, registered. It equals a<<n at done and holds through IDLE until the next accept.
- During SHIFT, r shows intermediate values. Consumers must qualify r with done.
- Arithmetic rules:
  - Pure logical shift; no sign handling.
  - b >= WIDTH gives r=0 and carry=a[0].
  - b=0 gives r=a and carry=0.

Decomposition:
- Shared alu_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the ALU_WIDTH=8 constant;
  - the saturation helper function min_shift(b, WIDTH).
- The block is a single FSM plus datapath, with no sub-module.
- The right-direction sequential variant will reuse the same package and FSM.

Test Plan:
- a=8'h81, b=1, start at cycle 0 -> done at cycle 2; r=8'h02, carry=1.
- a=8'hB5, b=3 -> done at cycle 4; r=8'hA8, carry=1; busy high during cycles 1-3.
- a=8'h5A, b=0 -> done at cycle 1; r=8'h5A, carry=0; busy never asserted.
- a=8'h01, b=8'd200 -> saturates to 8; done at cycle 9; r=8'h00, carry=1.
- Reset and handshake:
  - Start a=8'hFF, b=5, then rst=1 at cycle 2 -> cycle 3 has r=0, carry=0, busy=0, done=0, and no done pulse follows.
  - start pulses during busy are ignored.
  - start during a DONE cycle with a=8'h03, b=2 -> r=8'h0C, with done exactly 3 cycles later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the sequential-shifter state encoding, the ALU width,
// and the shift-amount saturation helper.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } shift_state_e;

    // Clamp a shift amount so that anything at or beyond the width shifts everything out.
    function automatic int unsigned min_shift(input int unsigned b, input int unsigned width);
        return (b >= width) ? width : b;
    endfunction

endpackage

// File: rtl/shift_left_sequential.sv
// Multi-cycle logical left shifter: one bit per clock, zero fill from the LSB,
// with a start/busy/done handshake and the last bit shifted out reported as carry.
module shift_left_sequential
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    shift_state_e     state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] n_sat;
    logic             accept;

    assign n_sat  = CNT_W'(min_shift(32'(b), WIDTH));
    assign accept = start && (state_q == StIdle || state_q == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        acc_q   <= a;
                        carry_q <= 1'b0;
                        cnt_q   <= n_sat;
                        if (n_sat == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StShift;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StShift: begin
                    acc_q   <= {acc_q[WIDTH-2:0], 1'b0};
                    carry_q <= acc_q[WIDTH-1];
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign r     = acc_q;
    assign carry = carry_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_shift_left_sequential.sv
// Directed bench for shift_left_sequential: expected results are queued at issue
// and popped when done is seen; outputs are sampled on the falling edge.
module tb_shift_left_sequential;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] r;
        logic         carry;
        int unsigned  n;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         carry;
    logic         busy;
    logic         done;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_fail;

    shift_left_sequential dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .r    (r),
        .carry(carry),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference: r = a << min(b,W), carry = a[W-n] for n>0.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int unsigned n;
        logic [W-1:0] av_l;
        n    = (int'(bv) >= int'(W)) ? W : int'(bv);
        av_l = av;
        e.n  = n;
        e.r  = (n >= W) ? '0 : W'(av_l << n);
        e.carry = (n == 0) ? 1'b0 : av_l[W-n];
        sb_q.push_back(e);
        a     = av;
        b     = bv;
        start = 1'b1;
    endtask

    // Called at a falling edge with start asserted; returns at the negedge where done is seen.
    task automatic wait_done(input string tag, input bit poke_busy);
        exp_t e;
        int   lat;
        bit   seen;
        e    = sb_q.pop_front();
        lat  = 0;
        seen = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (poke_busy && lat == 2) begin
                start = 1'b0;
                a     = 8'h00;
                b     = 8'h00;
            end
            chk({tag, "_busy"}, 32'(busy), 32'(lat <= int'(e.n)));
            if (done === 1'b1) begin
                seen = 1'b1;
            end else if (poke_busy && lat == 1) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'h01;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(e.n + 1));
        chk({tag, "_r"}, 32'(r), 32'(e.r));
        chk({tag, "_carry"}, 32'(carry), 32'(e.carry));
    endtask

    task automatic chk_hold(input string tag, input logic [W-1:0] rexp);
        @(negedge clk);
        chk({tag, "_hold_done"}, 32'(done), 32'd0);
        chk({tag, "_hold_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hold_r"}, 32'(r), 32'(rexp));
    endtask

    initial begin
        bit saw_done;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        start_op(8'h81, 8'd1);
        wait_done("b1", 1'b0);
        chk_hold("b1", 8'h02);

        start_op(8'hB5, 8'd3);
        wait_done("b3", 1'b0);
        chk_hold("b3", 8'hA8);

        start_op(8'h5A, 8'd0);
        wait_done("b0", 1'b0);
        chk_hold("b0", 8'h5A);

        start_op(8'h01, 8'd200);
        wait_done("bsat", 1'b0);
        chk_hold("bsat", 8'h00);

        start_op(8'h96, 8'd8);
        wait_done("b8", 1'b0);

        // start pulses and operand changes while busy must not disturb the op in flight
        @(negedge clk);
        start_op(8'hC3, 8'd6);
        wait_done("ign", 1'b1);
        chk_hold("ign", 8'hC0);

        // back-to-back: new start in the DONE cycle
        @(negedge clk);
        start_op(8'h40, 8'd2);
        wait_done("btb1", 1'b0);
        start_op(8'h03, 8'd2);
        wait_done("btb2", 1'b0);
        chk_hold("btb2", 8'h0C);

        // reset mid-shift
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy_pre", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_r", 32'(r), 32'd0);
        chk("rst_mid_carry", 32'(carry), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        chk("rst_mid_quiet", 32'(saw_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
